// File: rtl/seg7_scan_reader.sv
// Seven-segment scan bus reader: synchronizes the shared segment lines and the digit selects.
// It captures each digit after its pattern has held stable and decodes it back to a nibble.
module seg7_scan_reader #(
   parameter int NUM_DIG = 4,
   parameter int STABLE  = 8
) (
   input  logic                                              clk,
   input  logic                                              rst_n,
   input  logic [6:0]                                        seg_in,
   input  logic [NUM_DIG-1:0]                                dig_in,
   input  logic                                              clr,
   output logic [4*NUM_DIG-1:0]                              dout,
   output logic [NUM_DIG-1:0]                                dvld,
   output logic                                              upd,
   output logic [((NUM_DIG > 2) ? $clog2(NUM_DIG) : 1)-1:0]  upd_idx,
   output logic                                              err
);

   localparam int IDX_W = (NUM_DIG > 2) ? $clog2(NUM_DIG) : 1;
   localparam int CNT_W = $clog2(STABLE + 1);
   localparam int S_W   = NUM_DIG + 7;

   typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

   // Returns {legal digit, illegal pattern, nibble}.
   function automatic logic [5:0] decode(input logic [6:0] seg);
      case (seg)
         7'b1111110: decode = {2'b10, 4'h0};
         7'b0110000: decode = {2'b10, 4'h1};
         7'b1101101: decode = {2'b10, 4'h2};
         7'b1111001: decode = {2'b10, 4'h3};
         7'b0110011: decode = {2'b10, 4'h4};
         7'b1011011: decode = {2'b10, 4'h5};
         7'b1011111: decode = {2'b10, 4'h6};
         7'b1110000: decode = {2'b10, 4'h7};
         7'b1111111: decode = {2'b10, 4'h8};
         7'b1111011: decode = {2'b10, 4'h9};
         7'b0000000: decode = {2'b00, 4'hF};
         default:    decode = {2'b01, 4'hE};
      endcase
   endfunction

   state_t               state_q, state_d;
   logic [S_W-1:0]       sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [4*NUM_DIG-1:0] dout_q, dout_d;
   logic [NUM_DIG-1:0]   dvld_q, dvld_d;
   logic                 upd_q, upd_d, err_q, err_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [NUM_DIG-1:0]   s_dig;
   logic [5:0]           dec;
   logic                 chg, multi;

   always_comb begin
      sync1_d = {dig_in, seg_in};
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      s_dig   = sync2_q[S_W-1:7];
      dec     = decode(sync2_q[6:0]);
      chg     = (sync2_q != prev_q);
      multi   = ((s_dig & (s_dig - 1'b1)) != '0);
      state_d = state_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      dvld_d  = dvld_q;
      upd_d   = 1'b0;
      idx_d   = idx_q;
      err_d   = err_q;

      if (chg)
         cnt_d = CNT_W'(1);
      else if (cnt_q != CNT_W'(STABLE))
         cnt_d = cnt_q + 1'b1;

      // A change always restarts the settle window; capture only once per stable period.
      case (state_q)
         SETTLE: begin
            if (chg)
               state_d = (s_dig == '0) ? IDLE : SETTLE;
            else if (cnt_d == CNT_W'(STABLE)) begin
               state_d = DONE;
               if (multi)
                  err_d = 1'b1;
               else begin
                  for (int i = 0; i < NUM_DIG; i++) begin
                     if (s_dig[i]) begin
                        dout_d[4*i +: 4] = dec[3:0];
                        dvld_d[i]        = dec[5];
                        idx_d            = IDX_W'(i);
                     end
                  end
                  err_d = err_q | dec[4];
                  upd_d = 1'b1;
               end
            end
         end
         default: begin
            if (chg)
               state_d = (s_dig == '0) ? IDLE : SETTLE;
         end
      endcase

      if (clr) begin
         state_d = IDLE;
         cnt_d   = '0;
         dout_d  = '1;
         dvld_d  = '0;
         upd_d   = 1'b0;
         err_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         cnt_q   <= '0;
         dout_q  <= '1;
         dvld_q  <= '0;
         upd_q   <= 1'b0;
         idx_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         dvld_q  <= dvld_d;
         upd_q   <= upd_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
      end
   end

   assign dout    = dout_q;
   assign dvld    = dvld_q;
   assign upd     = upd_q;
   assign upd_idx = idx_q;
   assign err     = err_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Bench for seg7_scan_reader: decode table, timing scoreboard and multi-cycle corner cases.
module tb_seg7_scan_reader;

   localparam int NUM_DIG = 4;
   localparam int STABLE  = 8;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [6:0]           seg_in;
   logic [NUM_DIG-1:0]   dig_in;
   logic                 clr;
   logic [4*NUM_DIG-1:0] dout;
   logic [NUM_DIG-1:0]   dvld;
   logic                 upd;
   logic [1:0]           upd_idx;
   logic                 err;

   seg7_scan_reader #(.NUM_DIG(NUM_DIG), .STABLE(STABLE)) dut (
      .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_in(dig_in), .clr(clr),
      .dout(dout), .dvld(dvld), .upd(upd), .upd_idx(upd_idx), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] pos;
      logic [6:0] seg;
      logic [3:0] nib;
      logic       vld;
      logic       erb;
   } vec_t;

   typedef struct {
      int         cyc;
      logic [1:0] idx;
      logic [3:0] nib;
      logic       vld;
      logic       erb;
   } exp_t;

   vec_t vecs[13];
   exp_t sb[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Capture monitor: every Upd must match the oldest expectation, on its exact cycle.
   initial forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (upd === 1'b1) begin
         n_chk++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_upd cyc=%0d upd_idx=%0d dout=%h required no pulse", cyc, upd_idx, dout);
         end else begin
            e = sb.pop_front();
            if (cyc != e.cyc || upd_idx !== e.idx || dout[4*e.idx +: 4] !== e.nib ||
                dvld[e.idx] !== e.vld || err !== e.erb) begin
               n_err++;
               $display("FAIL capture got cyc=%0d idx=%0d nib=%h vld=%b err=%b required cyc=%0d idx=%0d nib=%h vld=%b err=%b",
                        cyc, upd_idx, dout[4*e.idx +: 4], dvld[e.idx], err, e.cyc, e.idx, e.nib, e.vld, e.erb);
            end
         end
      end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
         e = sb.pop_front();
         n_chk++;
         n_err++;
         $display("FAIL missed_upd at cyc=%0d required pulse at cyc=%0d idx=%0d", cyc, e.cyc, e.idx);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s got=%h required=%h", name, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic show(input logic [1:0] pos, input logic [6:0] seg, input logic [3:0] nib,
                       input logic vld, input logic erb);
      dig_in = 4'b0001 << pos;
      seg_in = seg;
      sb.push_back('{cyc + STABLE + 2, pos, nib, vld, erb});
   endtask

   task automatic gap();
      dig_in = '0;
      seg_in = '0;
      tick(4);
   endtask

   task automatic do_clr();
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
   endtask

   logic [6:0] pats[4];
   logic [3:0] vals[4];

   initial begin
      vecs[0]  = '{2'd1, 7'b1101101, 4'h2, 1'b1, 1'b0};
      vecs[1]  = '{2'd0, 7'b1111110, 4'h0, 1'b1, 1'b0};
      vecs[2]  = '{2'd1, 7'b0110000, 4'h1, 1'b1, 1'b0};
      vecs[3]  = '{2'd3, 7'b1111001, 4'h3, 1'b1, 1'b0};
      vecs[4]  = '{2'd0, 7'b0110011, 4'h4, 1'b1, 1'b0};
      vecs[5]  = '{2'd1, 7'b1011011, 4'h5, 1'b1, 1'b0};
      vecs[6]  = '{2'd2, 7'b1011111, 4'h6, 1'b1, 1'b0};
      vecs[7]  = '{2'd3, 7'b1110000, 4'h7, 1'b1, 1'b0};
      vecs[8]  = '{2'd0, 7'b1111111, 4'h8, 1'b1, 1'b0};
      vecs[9]  = '{2'd1, 7'b1111011, 4'h9, 1'b1, 1'b0};
      vecs[10] = '{2'd1, 7'b0000000, 4'hF, 1'b0, 1'b0};
      vecs[11] = '{2'd2, 7'b0000001, 4'hE, 1'b0, 1'b1};
      vecs[12] = '{2'd3, 7'b1000000, 4'hE, 1'b0, 1'b1};
      pats = '{7'b0110000, 7'b1111011, 7'b1111111, 7'b0110011};
      vals = '{4'h1, 4'h9, 4'h8, 4'h4};

      rst_n = 1'b0; clr = 1'b0; dig_in = '0; seg_in = '0;
      tick(3);
      check("reset_dout", dout, 16'hFFFF);
      check("reset_dvld", {12'd0, dvld}, 16'h0);
      check("reset_upd_idx_err", {13'd0, upd, upd_idx}, 16'h0);
      check("reset_err", {15'd0, err}, 16'h0);
      rst_n = 1'b1;
      tick(2);

      // Decode table: single digit captures, including a 20-cycle hold with one pulse.
      for (int i = 0; i < 13; i++) begin
         gap();
         do_clr();
         show(vecs[i].pos, vecs[i].seg, vecs[i].nib, vecs[i].vld, vecs[i].erb);
         tick(STABLE + 12);
         check($sformatf("vec%0d_nib", i), {12'd0, dout[4*vecs[i].pos +: 4]}, {12'd0, vecs[i].nib});
         check($sformatf("vec%0d_dvld", i), {12'd0, dvld}, {12'd0, 4'({vecs[i].vld}) << vecs[i].pos});
         check($sformatf("vec%0d_err", i), {15'd0, err}, {15'd0, vecs[i].erb});
      end

      // Illegal pattern, then blank on the same digit, then multi-hot select.
      gap();
      do_clr();
      show(2'd0, 7'b0000001, 4'hE, 1'b0, 1'b1);
      tick(16);
      check("illegal_err", {15'd0, err}, 16'h1);
      show(2'd0, 7'b0000000, 4'hF, 1'b0, 1'b1);
      tick(16);
      check("blank_dout", dout, 16'hFFFF);
      do_clr();
      check("clr_err", {15'd0, err}, 16'h0);
      dig_in = 4'b0011;
      seg_in = 7'b1111110;
      tick(16);
      check("multihot_err", {15'd0, err}, 16'h1);
      check("multihot_dout", dout, 16'hFFFF);

      // Clear landing on the capture edge of a pending digit.
      show(2'd1, 7'b1110000, 4'h7, 1'b1, 1'b1);
      tick(16);
      check("pre_clr_dout", dout, 16'hFF7F);
      dig_in = 4'b0100;
      seg_in = 7'b1111001;
      tick(STABLE + 1);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      tick(6);
      check("clr_win_dout", dout, 16'hFFFF);
      check("clr_win_dvld", {12'd0, dvld}, 16'h0);
      check("clr_win_err", {15'd0, err}, 16'h0);

      // Full scan, two rounds.
      gap();
      do_clr();
      for (int r = 0; r < 2; r++) begin
         for (int d = 0; d < 4; d++) begin
            show(2'(d), pats[d], vals[d], 1'b1, 1'b0);
            tick(16);
         end
      end
      check("scan_dout", dout, 16'h4891);
      check("scan_dvld", {12'd0, dvld}, 16'h000F);
      check("scan_err", {15'd0, err}, 16'h0);

      // Glitch during settle restarts the count.
      dig_in = 4'b0010;
      seg_in = 7'b1101101;
      tick(4);
      seg_in = 7'b0010010;
      tick(5);
      show(2'd1, 7'b1101101, 4'h2, 1'b1, 1'b0);
      tick(20);
      check("glitch_dout", dout, 16'h4821);
      check("glitch_err", {15'd0, err}, 16'h0);

      // Asynchronous reset in the middle of a settle window.
      show(2'd2, 7'b1011011, 4'h5, 1'b1, 1'b0);
      tick(16);
      dig_in = 4'b0001;
      seg_in = 7'b1011111;
      tick(4);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_dout", dout, 16'hFFFF);
      check("async_rst_dvld", {12'd0, dvld}, 16'h0);
      check("async_rst_upd_err", {14'd0, upd, err}, 16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      show(2'd0, 7'b1011111, 4'h6, 1'b1, 1'b0);
      tick(20);
      check("post_rst_dout", dout, 16'hFFF6);

      n_chk++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain got=%0d pending required=0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
